// File: rtl/param_alu_if.sv
// rtl/param_alu_if.sv - operand/handshake/result bundle for param_alu
interface param_alu_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic [2:0]         op;
   logic               start;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] result;

   modport master (
      output A, B, op, start,
      input  busy, done, result
   );

   modport slave (
      input  A, B, op, start,
      output busy, done, result
   );
endinterface

// File: rtl/param_alu.sv
// rtl/param_alu.sv - start/done ALU with busy, two-cycle logic ops and iterative multiply
module param_alu #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   param_alu_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_MAX = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL,
      S_WB
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0]   a_q, b_q;
   logic [2:0]         op_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] res_q;
   logic               done_q;
   logic               busy_q;

   logic [WIDTH:0]     sum_w, diff_w;
   logic [2*WIDTH-1:0] alu_d;
   logic [2*WIDTH-1:0] mcand_sh;
   logic [2*WIDTH-1:0] mul_add;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOP and the reserved opcode are accepted but never leave IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  OP_ADD, OP_AND, OP_XOR, OP_SUB, OP_MAX: state_d = S_EXEC;
                  OP_MUL:                                 state_d = S_MUL;
                  default:                                state_d = S_IDLE;
               endcase
            end
         end
         S_EXEC:  state_d = S_WB;
         S_MUL:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sum_w  = {1'b0, a_q} + {1'b0, b_q};
      diff_w = {1'b0, a_q} - {1'b0, b_q};
      alu_d  = '0;
      case (op_q)
         OP_ADD:  alu_d = {{(WIDTH-1){1'b0}}, sum_w};
         OP_AND:  alu_d = {{WIDTH{1'b0}}, a_q & b_q};
         OP_XOR:  alu_d = {{WIDTH{1'b0}}, a_q ^ b_q};
         // Bit WIDTH of the extended difference is the borrow, i.e. the sign.
         OP_SUB:  alu_d = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
         OP_MAX:  alu_d = {{WIDTH{1'b0}}, (a_q > b_q) ? a_q : b_q};
         default: alu_d = '0;
      endcase
   end

   always_comb begin
      mcand_sh = {{WIDTH{1'b0}}, a_q} << cnt_q;
      mul_add  = b_q[cnt_q] ? mcand_sh : '0;
   end

   // Every computed value lands in acc_q first; the WB state is the only
   // place result changes, which keeps done and result on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         cnt_q  <= '0;
         acc_q  <= '0;
         res_q  <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         done_q <= (state_q == S_WB);
         busy_q <= (state_d != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (state_d != S_IDLE) begin
                  a_q   <= bus.A;
                  b_q   <= bus.B;
                  op_q  <= bus.op;
                  cnt_q <= '0;
                  acc_q <= '0;
               end
            end
            S_EXEC: acc_q <= alu_d;
            S_MUL: begin
               acc_q <= acc_q + mul_add;
               cnt_q <= cnt_q + 1'b1;
            end
            S_WB:    res_q <= acc_q;
            default: ;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = res_q;
endmodule
